// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, byte indexing and the ShiftRows byte map.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_NB      = 4;

    typedef logic [AES_STATE_W-1:0] aes_state_t;

    // Byte position of s[r][c] in the column-major byte stream.
    function automatic int unsigned idx(input int unsigned r, input int unsigned c);
        return AES_NB * c + r;
    endfunction

    // ShiftRows (inverse=0) or InvShiftRows (inverse=1). Byte k sits at state[127-8k -: 8].
    function automatic aes_state_t shift_rows(input aes_state_t state, input logic inverse);
        aes_state_t  result;
        int unsigned src_c;
        result = '0;
        for (int unsigned r = 0; r < AES_NB; r++) begin
            for (int unsigned c = 0; c < AES_NB; c++) begin
                src_c = inverse ? ((c + AES_NB - r) % AES_NB) : ((c + r) % AES_NB);
                result[AES_STATE_W-1-8*idx(r, c) -: 8] = state[AES_STATE_W-1-8*idx(r, src_c) -: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational (Inv)ShiftRows byte permutation; pure wiring.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic [AES_STATE_W-1:0] state_in,
    output logic [AES_STATE_W-1:0] state_out
);

    // Route every byte to its shifted position.
    always_comb begin
        state_out = shift_rows(state_in, INVERSE);
    end

endmodule

// File: rtl/shift_rows_stage.sv
// Registered (Inv)ShiftRows stage with a 2-entry skid buffer on a valid/ready interface.
module shift_rows_stage
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int TAG_WIDTH  = 4,
    parameter bit INVERSE    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shiftRows_valid_in,
    output logic                  shiftRows_ready_out,
    input  logic [DATA_WIDTH-1:0] shiftRows_data_in,
    input  logic [TAG_WIDTH-1:0]  shiftRows_tag_in,
    output logic                  shiftRows_valid_out,
    input  logic                  shiftRows_ready_in,
    output logic [DATA_WIDTH-1:0] shiftRows_data_out,
    output logic [TAG_WIDTH-1:0]  shiftRows_tag_out
);

    if (DATA_WIDTH != AES_STATE_W) begin : g_bad_width
        $error("shift_rows_stage: DATA_WIDTH must be 128");
    end

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } skid_state_e;

    skid_state_e           state_q, state_d;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] or_data_q, sk_data_q, perm_data;
    logic [TAG_WIDTH-1:0]  or_tag_q, sk_tag_q;
    logic                  accept, transfer;
    logic                  load_or_in, load_or_sk, load_sk;

    shift_rows_perm #(
        .INVERSE (INVERSE)
    ) u_perm (
        .state_in  (shiftRows_data_in),
        .state_out (perm_data)
    );

    // valid_out is masked during reset so a held beat is never reported as transferred.
    assign shiftRows_valid_out = (state_q != ST_EMPTY) && !rst;
    assign shiftRows_ready_out = ready_q;
    assign shiftRows_data_out  = or_data_q;
    assign shiftRows_tag_out   = or_tag_q;

    assign accept   = shiftRows_valid_in && shiftRows_ready_out;
    assign transfer = shiftRows_valid_out && shiftRows_ready_in;

    // Skid FSM: decide next state and which register loads from where.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        load_or_in = 1'b0;
        load_or_sk = 1'b0;
        load_sk    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d    = ST_ONE;
                    load_or_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && transfer) begin
                    load_or_in = 1'b1;
                end else if (accept) begin
                    state_d = ST_FULL;
                    load_sk = 1'b1;
                end else if (transfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (transfer) begin
                    state_d    = ST_ONE;
                    load_or_sk = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State, registered ready and the OR/SK data registers.
    always_ff @(posedge clk) begin
        // NOTE: state is assigned with <= so every flop samples pre-edge values, whatever the statement order.
        if (rst) begin
            state_q   <= ST_EMPTY;
            ready_q   <= 1'b0;
            // NOTE: the datapath registers are reset only because data_out/tag_out must read zero after reset.
            or_data_q <= '0;
            or_tag_q  <= '0;
            sk_data_q <= '0;
            sk_tag_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
            if (load_or_in) begin
                or_data_q <= perm_data;
                or_tag_q  <= shiftRows_tag_in;
            end else if (load_or_sk) begin
                or_data_q <= sk_data_q;
                or_tag_q  <= sk_tag_q;
            end
            if (load_sk) begin
                sk_data_q <= perm_data;
                sk_tag_q  <= shiftRows_tag_in;
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_stage.sv
// Self-checking bench: an encrypt stage and a decrypt stage, optionally chained for round trips.
module tb_shift_rows_stage;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         chain = 1'b0;

    logic         enc_valid_in = 1'b0;
    logic [127:0] enc_data_in = '0;
    logic [3:0]   enc_tag_in = '0;
    logic         tb_enc_ready = 1'b0;
    logic         enc_ready_in, enc_ready_out, enc_valid_out;
    logic [127:0] enc_data_out;
    logic [3:0]   enc_tag_out;

    logic         tb_dec_valid = 1'b0;
    logic [127:0] tb_dec_data = '0;
    logic [3:0]   tb_dec_tag = '0;
    logic         dec_ready_in = 1'b0;
    logic         dec_valid_in, dec_ready_out, dec_valid_out;
    logic [127:0] dec_data_in, dec_data_out;
    logic [3:0]   dec_tag_in, dec_tag_out;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t enc_vecs[6];
    vec_t dec_vecs[3];

    assign enc_ready_in = chain ? dec_ready_out : tb_enc_ready;
    assign dec_valid_in = chain ? enc_valid_out : tb_dec_valid;
    assign dec_data_in  = chain ? enc_data_out  : tb_dec_data;
    assign dec_tag_in   = chain ? enc_tag_out   : tb_dec_tag;

    shift_rows_stage #(.DATA_WIDTH(128), .TAG_WIDTH(4), .INVERSE(1'b0)) u_enc (
        .clk                 (clk),
        .rst                 (rst),
        .shiftRows_valid_in  (enc_valid_in),
        .shiftRows_ready_out (enc_ready_out),
        .shiftRows_data_in   (enc_data_in),
        .shiftRows_tag_in    (enc_tag_in),
        .shiftRows_valid_out (enc_valid_out),
        .shiftRows_ready_in  (enc_ready_in),
        .shiftRows_data_out  (enc_data_out),
        .shiftRows_tag_out   (enc_tag_out)
    );

    shift_rows_stage #(.DATA_WIDTH(128), .TAG_WIDTH(4), .INVERSE(1'b1)) u_dec (
        .clk                 (clk),
        .rst                 (rst),
        .shiftRows_valid_in  (dec_valid_in),
        .shiftRows_ready_out (dec_ready_out),
        .shiftRows_data_in   (dec_data_in),
        .shiftRows_tag_in    (dec_tag_in),
        .shiftRows_valid_out (dec_valid_out),
        .shiftRows_ready_in  (dec_ready_in),
        .shiftRows_data_out  (dec_data_out),
        .shiftRows_tag_out   (dec_tag_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    // Reference model: hand-derived source byte for each output byte.
    function automatic logic [127:0] ref_perm(input logic [127:0] d, input bit inv);
        int enc_map[16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
        int inv_map[16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
        logic [127:0] r;
        int src;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            src = inv ? inv_map[k] : enc_map[k];
            r[127-8*k -: 8] = d[127-8*src -: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random stream with a scoreboard. chain=1 observes the decrypt output of enc->dec.
    task automatic run_stream(input bit use_chain, input int n_beats, input bit rand_ready);
        logic [131:0] sb[$];
        logic [131:0] head;
        logic         rdy, obs_valid;
        logic [127:0] obs_data;
        logic [3:0]   obs_tag;
        int           sent = 0;
        int           cycles = 0;
        int           budget = 4 * n_beats + 50;
        chain = use_chain;
        while ((sent < n_beats || sb.size() != 0) && cycles < budget) begin
            if (!(enc_valid_in && !enc_ready_out)) begin
                if (sent < n_beats && (use_chain || $urandom_range(3) != 0)) begin
                    enc_valid_in = 1'b1;
                    enc_data_in  = rand128();
                    enc_tag_in   = 4'($urandom_range(15));
                end else begin
                    enc_valid_in = 1'b0;
                end
            end
            rdy = rand_ready ? 1'($urandom_range(1)) : 1'b1;
            if (use_chain) dec_ready_in = rdy;
            else           tb_enc_ready = rdy;
            obs_valid = use_chain ? dec_valid_out : enc_valid_out;
            obs_data  = use_chain ? dec_data_out  : enc_data_out;
            obs_tag   = use_chain ? dec_tag_out   : enc_tag_out;
            if (obs_valid && rdy) begin
                if (sb.size() == 0) begin
                    check("stream_extra_valid", {127'd0, obs_valid}, 128'd0);
                end else begin
                    head = sb.pop_front();
                    check("stream_data", obs_data, head[127:0]);
                    check("stream_tag", {124'd0, obs_tag}, {124'd0, head[131:128]});
                end
            end
            if (enc_valid_in && enc_ready_out) begin
                sb.push_back({enc_tag_in, use_chain ? enc_data_in : ref_perm(enc_data_in, 1'b0)});
                sent++;
            end
            tick();
            cycles++;
        end
        enc_valid_in = 1'b0;
        check("stream_sent", sent, n_beats);
        check("stream_left", sb.size(), 0);
        tick();
        chain = 1'b0;
    endtask

    initial begin
        logic [127:0] a, b, c;
        logic [127:0] exp_q[16];
        int bubbles;

        enc_vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
        enc_vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00050a0f04090e03080d02070c01060b};
        enc_vecs[2] = '{128'h101112131415161718191a1b1c1d1e1f, 128'h10151a1f14191e13181d12171c11161b};
        enc_vecs[3] = '{128'haa000000bb000000cc000000dd000000, 128'haa000000bb000000cc000000dd000000};
        enc_vecs[4] = '{128'h00110000002200000033000000440000, 128'h00220000003300000044000000110000};
        enc_vecs[5] = '{{128{1'b1}},                          {128{1'b1}}};
        dec_vecs[0] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'hd42711aee0bf98f1b8b45de51e415230};
        dec_vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h000d0a0704010e0b0805020f0c090603};
        dec_vecs[2] = '{128'h10151a1f14191e13181d12171c11161b, 128'h101112131415161718191a1b1c1d1e1f};

        // Reset held 3 cycles with a beat offered.
        rst = 1'b1;
        enc_valid_in = 1'b1;
        enc_data_in  = enc_vecs[0].din;
        tb_enc_ready = 1'b1;
        repeat (3) begin
            tick();
            check("rst_valid_out", {127'd0, enc_valid_out}, 128'd0);
            check("rst_ready_out", {127'd0, enc_ready_out}, 128'd0);
            check("rst_data_out", enc_data_out, 128'd0);
            check("rst_tag_out", {124'd0, enc_tag_out}, 128'd0);
        end
        enc_valid_in = 1'b0;
        rst = 1'b0;
        tick();
        check("rel_ready_out", {127'd0, enc_ready_out}, 128'd1);
        check("rel_valid_out", {127'd0, enc_valid_out}, 128'd0);

        // Encrypt vector table, back to back.
        for (int i = 0; i < 6; i++) begin
            enc_valid_in = 1'b1;
            enc_data_in  = enc_vecs[i].din;
            enc_tag_in   = 4'(i);
            tick();
            check("enc_vec_valid", {127'd0, enc_valid_out}, 128'd1);
            check("enc_vec_data", enc_data_out, enc_vecs[i].dout);
            check("enc_vec_tag", {124'd0, enc_tag_out}, 128'(i));
        end
        enc_valid_in = 1'b0;
        tick();
        check("enc_idle_valid", {127'd0, enc_valid_out}, 128'd0);

        // Decrypt vector table.
        dec_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tb_dec_valid = 1'b1;
            tb_dec_data  = dec_vecs[i].din;
            tb_dec_tag   = 4'(i + 8);
            tick();
            check("dec_vec_valid", {127'd0, dec_valid_out}, 128'd1);
            check("dec_vec_data", dec_data_out, dec_vecs[i].dout);
            check("dec_vec_tag", {124'd0, dec_tag_out}, 128'(i + 8));
        end
        tb_dec_valid = 1'b0;
        tick();

        // Round trip enc -> dec must be the identity.
        run_stream(1'b1, 1000, 1'b0);

        // 16 back-to-back beats with tags 0..15, no bubbles allowed.
        tb_enc_ready = 1'b1;
        bubbles = 0;
        for (int i = 0; i < 16; i++) begin
            enc_valid_in = 1'b1;
            enc_data_in  = rand128();
            enc_tag_in   = 4'(i);
            exp_q[i]     = ref_perm(enc_data_in, 1'b0);
            tick();
            if (!enc_valid_out) bubbles++;
            check("b2b_tag", {124'd0, enc_tag_out}, 128'(i));
            check("b2b_data", enc_data_out, exp_q[i]);
        end
        enc_valid_in = 1'b0;
        check("b2b_bubbles", bubbles, 0);
        tick();

        // Backpressure: 3 beats offered while ready_in=0; only 2 fit.
        a = rand128();
        b = rand128();
        c = rand128();
        tb_enc_ready = 1'b0;
        enc_valid_in = 1'b1;
        enc_data_in  = a;
        enc_tag_in   = 4'd1;
        tick();
        check("bp_first_valid", {127'd0, enc_valid_out}, 128'd1);
        check("bp_first_ready", {127'd0, enc_ready_out}, 128'd1);
        enc_data_in = b;
        enc_tag_in  = 4'd2;
        tick();
        check("bp_full_ready", {127'd0, enc_ready_out}, 128'd0);
        check("bp_full_data", enc_data_out, ref_perm(a, 1'b0));
        enc_data_in = c;
        enc_tag_in  = 4'd3;
        tick();
        check("bp_stall_ready", {127'd0, enc_ready_out}, 128'd0);
        check("bp_stall_data", enc_data_out, ref_perm(a, 1'b0));
        check("bp_stall_tag", {124'd0, enc_tag_out}, 128'd1);
        tb_enc_ready = 1'b1;
        tick();
        check("bp_drain1_data", enc_data_out, ref_perm(b, 1'b0));
        check("bp_drain1_tag", {124'd0, enc_tag_out}, 128'd2);
        check("bp_drain1_ready", {127'd0, enc_ready_out}, 128'd1);
        tick();
        check("bp_drain2_data", enc_data_out, ref_perm(c, 1'b0));
        check("bp_drain2_tag", {124'd0, enc_tag_out}, 128'd3);
        enc_valid_in = 1'b0;
        tick();
        check("bp_empty_valid", {127'd0, enc_valid_out}, 128'd0);

        // Random valid and ready with a scoreboard.
        run_stream(1'b0, 300, 1'b1);

        // Reset while FULL discards the beats.
        tb_enc_ready = 1'b0;
        enc_valid_in = 1'b1;
        enc_data_in  = rand128();
        tick();
        enc_data_in = rand128();
        tick();
        check("rf_full_ready", {127'd0, enc_ready_out}, 128'd0);
        rst = 1'b1;
        tick();
        check("rf_rst_valid", {127'd0, enc_valid_out}, 128'd0);
        check("rf_rst_ready", {127'd0, enc_ready_out}, 128'd0);
        check("rf_rst_data", enc_data_out, 128'd0);
        rst = 1'b0;
        enc_valid_in = 1'b0;
        tick();
        check("rf_rel_ready", {127'd0, enc_ready_out}, 128'd1);
        check("rf_rel_valid", {127'd0, enc_valid_out}, 128'd0);
        tb_enc_ready = 1'b1;
        enc_valid_in = 1'b1;
        enc_data_in  = 128'h000102030405060708090a0b0c0d0e0f;
        enc_tag_in   = 4'd5;
        tick();
        check("rf_post_valid", {127'd0, enc_valid_out}, 128'd1);
        check("rf_post_data", enc_data_out, 128'h00050a0f04090e03080d02070c01060b);
        enc_valid_in = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
